// File: rtl/cpu_mem_pkg.sv
// Shared types for the unified memory port arbiter: FSM state, port owner and latched request payload.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Fetches are always full-word reads.
  localparam logic [3:0] FETCH_BE = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and memory-side handshake of the arbiter; slave = arbiter view, master = environment view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
    input  mem_ack, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
    output mem_ack, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational fetch/data winner selection; data has priority. With IF_STARVE_GUARD_EN a counter of
// fetch losses forces a fetch win after STARVE_MAX consecutive losses. Zero latency, no backpressure of its own.
module mem_arb_pick #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
`ifdef IF_STARVE_GUARD_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic arb_en_i,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic if_win_o,
  output logic d_win_o
);

  if ((2 ** CNT_W) <= STARVE_MAX) begin : g_bad_cnt_w
    $error("mem_arb_pick: CNT_W too narrow to hold STARVE_MAX");
  end

`ifdef IF_STARVE_GUARD_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             force_if;

  assign force_if = (cnt_q == CNT_W'(STARVE_MAX));

  always_comb begin
    if_win_o = arb_en_i & if_req_i & (~d_req_i | force_if);
    d_win_o  = arb_en_i & d_req_i & ~(if_req_i & force_if);
    cnt_d    = cnt_q;
    // Only contested arbitrations that fetch loses count toward starvation.
    if (if_win_o) begin
      cnt_d = '0;
    end else if (d_win_o & if_req_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    if_win_o = arb_en_i & if_req_i & ~d_req_i;
    d_win_o  = arb_en_i & d_req_i;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported I/D memory arbiter: one transaction at a time, gnt in IDLE, rvalid earliest one cycle after gnt.
// Losing requester simply stays pending (no gnt). Optional fetch starvation guard: IF_STARVE_GUARD_EN.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  mem_req_t   pay_q, pay_d;

  logic arb_en;
  logic if_win, d_win;
  logic deliver;
  logic busy;

  assign arb_en = (state_q == IDLE) & ~rst;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_pick (
`ifdef IF_STARVE_GUARD_EN
    .clk        (clk),
    .rst        (rst),
`endif
    .arb_en_i   (arb_en),
    .if_req_i   (bus.if_req),
    .d_req_i    (bus.d_req),
    .if_win_o   (if_win),
    .d_win_o    (d_win)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    pay_d   = pay_q;
    case (state_q)
      IDLE: begin
        if (d_win) begin
          state_d = REQ;
          owner_d = OWN_D;
          pay_d   = '{we: bus.d_we, be: bus.d_be, addr: bus.d_addr, wdata: bus.d_wdata};
        end else if (if_win) begin
          state_d = REQ;
          owner_d = OWN_IF;
          pay_d   = '{we: 1'b0, be: FETCH_BE, addr: bus.if_addr, wdata: 32'h0};
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          state_d = bus.mem_rvalid ? IDLE : RESP;
        end
      end
      RESP: begin
        if (bus.mem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      pay_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      pay_q   <= pay_d;
    end
  end

  // A response arriving while reset is asserted belongs to an abandoned transaction.
  assign deliver = ~rst & bus.mem_rvalid &
                   (((state_q == REQ) & bus.mem_ack) | (state_q == RESP));
  assign busy    = (state_q != IDLE);

  assign bus.if_gnt    = if_win;
  assign bus.d_gnt     = d_win;
  assign bus.if_rvalid = deliver & (owner_q == OWN_IF);
  assign bus.d_rvalid  = deliver & (owner_q == OWN_D);
  assign bus.if_rdata  = (~rst & busy & (owner_q == OWN_IF)) ? bus.mem_rdata : 32'h0;
  assign bus.d_rdata   = (~rst & busy & (owner_q == OWN_D))  ? bus.mem_rdata : 32'h0;

  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_we    = pay_q.we;
  assign bus.mem_be    = pay_q.be;
  assign bus.mem_addr  = pay_q.addr;
  assign bus.mem_wdata = pay_q.wdata;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by random traffic, all outputs compared each cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;
`ifdef IF_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: is a transaction outstanding, has memory accepted it, who owns it, what was captured.
  bit          m_busy = 1'b0;
  bit          m_acked = 1'b0;
  bit          m_own_d = 1'b0;
  bit          m_pay_known = 1'b1;
  bit          m_pay_full = 1'b1;
  logic        m_we = 1'b0;
  logic [3:0]  m_be = 4'h0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wdata = 32'h0;
  int          m_starve = 0;

  bit e_fw, e_dw, e_deliver;
  int last_gnt = 0;   // 0 none, 1 fetch, 2 data

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs for this cycle are already applied (1 time unit after the edge); compare mid-cycle.
  task automatic sample();
    #3;
    e_fw = 1'b0;
    e_dw = 1'b0;
    e_deliver = 1'b0;
    if (!rst && !m_busy) begin
      e_fw = bus.if_req && (!bus.d_req || (GUARD && m_starve == STARVE_MAX));
      e_dw = bus.d_req && !e_fw;
    end
    if (!rst && m_busy) e_deliver = bus.mem_rvalid && (m_acked || bus.mem_ack);
    chk1("if_gnt", bus.if_gnt, e_fw);
    chk1("d_gnt", bus.d_gnt, e_dw);
    chk1("mem_req", bus.mem_req, m_busy && !m_acked);
    chk1("busy", bus.busy, m_busy);
    chk1("if_rvalid", bus.if_rvalid, e_deliver && !m_own_d);
    chk1("d_rvalid", bus.d_rvalid, e_deliver && m_own_d);
    chk32("if_rdata", bus.if_rdata, (!rst && m_busy && !m_own_d) ? bus.mem_rdata : 32'h0);
    chk32("d_rdata", bus.d_rdata, (!rst && m_busy && m_own_d) ? bus.mem_rdata : 32'h0);
    if (m_pay_known) begin
      chk32("mem_addr", bus.mem_addr, m_addr);
      chk1("mem_we", bus.mem_we, m_we);
      if (m_pay_full) begin
        chk32("mem_be", 32'(bus.mem_be), 32'(m_be));
        chk32("mem_wdata", bus.mem_wdata, m_wdata);
      end
    end
    last_gnt = e_fw ? 1 : (e_dw ? 2 : 0);
  endtask

  task automatic advance();
    if (rst) begin
      m_busy = 1'b0; m_acked = 1'b0; m_own_d = 1'b0; m_starve = 0;
      m_we = 1'b0; m_be = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
      m_pay_known = 1'b1; m_pay_full = 1'b1;
    end else if (!m_busy) begin
      if (e_dw) begin
        m_busy = 1'b1; m_acked = 1'b0; m_own_d = 1'b1;
        m_we = bus.d_we; m_be = bus.d_be; m_addr = bus.d_addr; m_wdata = bus.d_wdata;
        m_pay_known = 1'b1; m_pay_full = 1'b1;
        if (bus.if_req) m_starve++;
      end else if (e_fw) begin
        m_busy = 1'b1; m_acked = 1'b0; m_own_d = 1'b0;
        m_we = 1'b0; m_addr = bus.if_addr;
        m_pay_known = 1'b1; m_pay_full = 1'b0;
        m_starve = 0;
      end
    end else if (e_deliver) begin
      m_busy = 1'b0;
      m_pay_known = 1'b0;
    end else if (bus.mem_ack) begin
      m_acked = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int grant_seq[$];
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;

    // Reset, with a fetch request already present.
    @(posedge clk);
    #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h44;
    sample();
    chk1("rst_if_gnt", bus.if_gnt, 1'b0);
    chk32("rst_mem_addr", bus.mem_addr, 32'h0);
    advance();
    bus.if_req = 1'b0;
    rst = 1'b0;
    step();

    // Fetch alone, memory responds one cycle after ack.
    bus.if_req = 1'b1; bus.if_addr = 32'h8;
    sample(); chk1("t1_if_gnt", bus.if_gnt, 1'b1); advance();
    bus.if_req = 1'b0; bus.if_addr = 32'h1234_5678; bus.mem_ack = 1'b1;
    sample(); chk32("t1_mem_addr", bus.mem_addr, 32'h8); chk1("t1_mem_req", bus.mem_req, 1'b1); advance();
    bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0010_8133;
    sample();
    chk1("t1_if_rvalid", bus.if_rvalid, 1'b1);
    chk32("t1_if_rdata", bus.if_rdata, 32'h0010_8133);
    chk1("t1_d_rvalid", bus.d_rvalid, 1'b0);
    advance();
    bus.mem_rvalid = 1'b0;
    step();

    // Simultaneous fetch and load: data first, fetch after one IDLE cycle.
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h40;
    sample(); chk1("t2_d_gnt", bus.d_gnt, 1'b1); chk1("t2_if_gnt", bus.if_gnt, 1'b0); advance();
    bus.d_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_0001;
    sample();
    chk32("t2_mem_addr", bus.mem_addr, 32'h40);
    chk1("t2_d_rvalid", bus.d_rvalid, 1'b1);
    chk32("t2_d_rdata", bus.d_rdata, 32'hCAFE_0001);
    chk32("t2_if_rdata", bus.if_rdata, 32'h0);
    chk1("t2_if_gnt_busy", bus.if_gnt, 1'b0);
    advance();
    bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0;
    sample(); chk1("t2_if_gnt_idle", bus.if_gnt, 1'b1); advance();
    bus.if_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h13;
    sample(); chk32("t2_if_addr", bus.mem_addr, 32'h100); chk1("t2_if_rvalid", bus.if_rvalid, 1'b1); advance();
    bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0;
    step();

    // Store with ack delayed three cycles while port inputs churn.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEAD_BEEF;
    sample(); chk1("t3_d_gnt", bus.d_gnt, 1'b1); advance();
    for (int i = 0; i < 3; i++) begin
      bus.d_req = 1'($urandom_range(0, 1)); bus.d_we = 1'($urandom_range(0, 1));
      bus.d_be = 4'($urandom); bus.d_addr = $urandom; bus.d_wdata = $urandom;
      bus.if_req = 1'($urandom_range(0, 1)); bus.if_addr = $urandom;
      bus.mem_rvalid = 1'($urandom_range(0, 1)); bus.mem_rdata = $urandom;
      sample();
      chk1("t3_mem_req", bus.mem_req, 1'b1);
      chk1("t3_mem_we", bus.mem_we, 1'b1);
      chk32("t3_mem_be", 32'(bus.mem_be), 32'h3);
      chk32("t3_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      chk32("t3_mem_addr", bus.mem_addr, 32'h200);
      chk1("t3_no_rvalid", bus.d_rvalid, 1'b0);
      advance();
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_ack = 1'b1;
    sample(); chk1("t3_ack_no_rvalid", bus.d_rvalid, 1'b0); advance();
    bus.mem_ack = 1'b0;
    sample(); chk1("t3_resp_mem_req", bus.mem_req, 1'b0); chk1("t3_resp_busy", bus.busy, 1'b1); advance();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = $urandom;
    sample(); chk1("t3_d_rvalid", bus.d_rvalid, 1'b1); advance();
    bus.mem_rvalid = 1'b0;
    sample(); chk1("t3_one_pulse", bus.d_rvalid, 1'b0); chk1("t3_idle", bus.busy, 1'b0); advance();

    // Reset while waiting for the response; the late response is dropped.
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    step();
    bus.if_req = 1'b0; bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF;
    sample();
    chk1("t5_mem_req", bus.mem_req, 1'b0);
    chk1("t5_busy", bus.busy, 1'b0);
    chk1("t5_if_rvalid", bus.if_rvalid, 1'b0);
    chk1("t5_d_rvalid", bus.d_rvalid, 1'b0);
    chk32("t5_mem_addr", bus.mem_addr, 32'h0);
    advance();
    bus.mem_rvalid = 1'b0;
    step();

    // Both ports request continuously with an instant memory.
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h600;
    bus.mem_ack = 1'b1; bus.mem_rvalid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sample();
      if (bus.if_gnt) grant_seq.push_back(1);
      else if (bus.d_gnt) grant_seq.push_back(2);
      advance();
    end
    chk32("t6_grant_count", 32'(grant_seq.size()), 32'd6);
    foreach (grant_seq[k]) chk32("t6_grant", 32'(grant_seq[k]), (GUARD && k == STARVE_MAX) ? 32'd1 : 32'd2);
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0;
    step();
    step();

    // Random traffic; requesters hold until granted, memory and reset are random.
    for (int c = 0; c < 400; c++) begin
      if (last_gnt == 1 || !bus.if_req) begin
        bus.if_req = 1'($urandom_range(0, 1));
        bus.if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (last_gnt == 2 || !bus.d_req) begin
        bus.d_req = 1'($urandom_range(0, 1));
        bus.d_we = 1'($urandom_range(0, 1));
        bus.d_be = 4'($urandom);
        bus.d_addr = $urandom;
        bus.d_wdata = $urandom;
      end
      bus.mem_ack = ($urandom_range(0, 2) == 0);
      bus.mem_rvalid = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;
      rst = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
